// File: rtl/mont_pkg.sv
// ---------------------------------------------------------------------------
// mont_pkg
// Shared constants and types for the Montgomery multiplier front end.
//   SIZE_INPUT : operand width in bits
//   WORD_SIZE  : bus / word width in bits
//   ITERATION  : words per operand
//   WEIGHT_W   : width of a word-sum weight (never wraps for 16 words)
//   N          : 1024-bit modulus, identical to the multiplier's constant
//   loader_state_e : operand loader FSM encoding
// ---------------------------------------------------------------------------
package mont_pkg;

  localparam int SIZE_INPUT = 1024;
  localparam int WORD_SIZE  = 64;
  localparam int ITERATION  = SIZE_INPUT / WORD_SIZE;
  localparam int WEIGHT_W   = WORD_SIZE + ITERATION;
  localparam int TOTAL_WORDS = 2 * ITERATION;

  // Modulus, most-significant word first. Word 0 is odd as Montgomery requires.
  localparam logic [SIZE_INPUT-1:0] N = {
    64'hC90F_DAA2_2168_C234, 64'hC4C6_628B_80DC_1CD1,
    64'h2902_4E08_8A67_CC74, 64'h020B_BEA6_3B13_9B22,
    64'h514A_0879_8E34_04DD, 64'hEF95_19B3_CD3A_431B,
    64'h302B_0A6D_F25F_1437, 64'h4FE1_356D_6D51_C245,
    64'hE485_B576_625E_7EC6, 64'hF44C_42E9_A637_ED6B,
    64'h0BFF_5CB6_F406_B7ED, 64'hEE38_6BFB_5A89_9FA5,
    64'hAE9F_2411_7C4B_1FE6, 64'h4928_6651_ECE4_5B3D,
    64'hC200_7CB8_A163_BF05, 64'h9823_7E4C_9E3E_A1A7
  };

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_U = 3'd1,
    ST_LOAD_V = 3'd2,
    ST_CHECK  = 3'd3,
    ST_STREAM = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_e;

endpackage

// File: rtl/mont_operand_loader_if.sv
// ---------------------------------------------------------------------------
// mont_operand_loader_if
// Word channel into the loader and word stream out to the multiplier.
//   in_word/in_valid : operand words from the source (LSW first)
//   in_ready         : loader accepts in_word this cycle
//   bus              : word stream to the multiplier
//   mul_reset        : active-high reset held on the multiplier
// Modports: master = source/multiplier side, slave = the loader.
// ---------------------------------------------------------------------------
interface mont_operand_loader_if;
  import mont_pkg::*;

  logic [WORD_SIZE-1:0] in_word;
  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] bus;
  logic                 mul_reset;

  modport master (
    output in_word,
    output in_valid,
    input  in_ready,
    input  bus,
    input  mul_reset
  );

  modport slave (
    input  in_word,
    input  in_valid,
    output in_ready,
    output bus,
    output mul_reset
  );

endinterface

// File: rtl/mont_serial_lt.sv
// ---------------------------------------------------------------------------
// mont_serial_lt
// Word-serial "operand < N" comparator plus word-sum accumulator.
//   clk, reset_n : clock, async active-low reset
//   clr          : restart the chain; with en the current word becomes word 0,
//                  without en borrow and weight are zeroed
//   en           : fold word/n_word into the chain this edge
//   word, n_word : operand word and modulus word of the same index
//   borrow       : 1 after the last word means operand < N
//   weight       : zero-extended sum of the folded words
// ---------------------------------------------------------------------------
module mont_serial_lt
  import mont_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [WORD_SIZE-1:0] word,
  input  logic [WORD_SIZE-1:0] n_word,
  output logic                 borrow,
  output logic [WEIGHT_W-1:0]  weight
);

  logic                 borrow_in_s;
  logic [WEIGHT_W-1:0]  weight_base_s;
  logic [WORD_SIZE:0]   n_plus_s;

  // Chain inputs; n_word+borrow is one bit wider so an all-ones N word cannot wrap.
  always_comb begin
    borrow_in_s   = 1'b0;
    weight_base_s = {WEIGHT_W{1'b0}};
    if (clr) begin
      borrow_in_s   = 1'b0;
      weight_base_s = {WEIGHT_W{1'b0}};
    end else begin
      borrow_in_s   = borrow;
      weight_base_s = weight;
    end
    n_plus_s = {1'b0, n_word} + {{WORD_SIZE{1'b0}}, borrow_in_s};
  end

  // Borrow and weight registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      borrow <= 1'b0;
      weight <= {WEIGHT_W{1'b0}};
    end else if (en) begin
      borrow <= ({1'b0, word} < n_plus_s);
      weight <= weight_base_s + {{(WEIGHT_W-WORD_SIZE){1'b0}}, word};
    end else if (clr) begin
      borrow <= 1'b0;
      weight <= {WEIGHT_W{1'b0}};
    end
  end

endmodule

// File: rtl/mont_operand_loader.sv
// ---------------------------------------------------------------------------
// mont_operand_loader
// Buffers the 16 u words and 16 v words, range-checks both against N,
// computes their word-sum weights, then releases the multiplier from reset
// and streams u then v onto its bus one word per cycle.
//   clk, reset_n : clock, async active-low reset
//   start        : begin a new load (honoured in IDLE/DONE/ERR only)
//   io           : word channel in, bus/mul_reset out (slave modport)
//   u_weight     : sum of the u words
//   v_weight     : sum of the v words
//   range_err    : u>=N or v>=N, held until the next accepted start
//   stream_done  : one-cycle pulse after the last word left the bus
// ---------------------------------------------------------------------------
module mont_operand_loader
  import mont_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  mont_operand_loader_if.slave io,
  output logic [WEIGHT_W-1:0] u_weight,
  output logic [WEIGHT_W-1:0] v_weight,
  output logic                range_err,
  output logic                stream_done
);

  loader_state_e        state_r;
  logic [5:0]           idx_r;
  logic                 in_ready_r;
  logic [WORD_SIZE-1:0] bus_r;
  logic                 mul_reset_r;
  logic [WEIGHT_W-1:0]  u_weight_r;
  logic [WEIGHT_W-1:0]  v_weight_r;
  logic                 range_err_r;
  logic                 stream_done_r;
  logic                 u_lt_r;
  logic [WORD_SIZE-1:0] buffer_r [TOTAL_WORDS];

  logic                 load_state_s;
  logic                 idle_like_s;
  logic                 accept_s;
  logic                 clr_s;
  logic [WORD_SIZE-1:0] n_word_s;
  logic                 borrow_s;
  logic [WEIGHT_W-1:0]  weight_s;

  assign io.in_ready  = in_ready_r;
  assign io.bus       = bus_r;
  assign io.mul_reset = mul_reset_r;
  assign u_weight     = u_weight_r;
  assign v_weight     = v_weight_r;
  assign range_err    = range_err_r;
  assign stream_done  = stream_done_r;

  // Handshake decode. The chain restarts on an accepted start, and again on
  // the first v word so the v comparison begins with borrow_in=0.
  always_comb begin
    load_state_s = (state_r == ST_LOAD_U) || (state_r == ST_LOAD_V);
    idle_like_s  = (state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR);
    accept_s     = io.in_valid && in_ready_r && load_state_s;
    if (idle_like_s && start) begin
      clr_s = 1'b1;
    end else if ((state_r == ST_LOAD_V) && (idx_r == 6'd16) && accept_s) begin
      clr_s = 1'b1;
    end else begin
      clr_s = 1'b0;
    end
    n_word_s = N[{idx_r[3:0], 6'd0} +: WORD_SIZE];
  end

  mont_serial_lt u_serial_lt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr_s),
    .en      (accept_s),
    .word    (io.in_word),
    .n_word  (n_word_s),
    .borrow  (borrow_s),
    .weight  (weight_s)
  );

  // Operand buffer; contents are don't-care after reset so it carries none.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      buffer_r[idx_r[4:0]] <= io.in_word;
    end
  end

  // Loader FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      idx_r         <= 6'd0;
      in_ready_r    <= 1'b0;
      bus_r         <= {WORD_SIZE{1'b0}};
      mul_reset_r   <= 1'b1;
      u_weight_r    <= {WEIGHT_W{1'b0}};
      v_weight_r    <= {WEIGHT_W{1'b0}};
      range_err_r   <= 1'b0;
      stream_done_r <= 1'b0;
      u_lt_r        <= 1'b0;
    end else begin
      stream_done_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_r     <= ST_LOAD_U;
            idx_r       <= 6'd0;
            in_ready_r  <= 1'b1;
            bus_r       <= {WORD_SIZE{1'b0}};
            mul_reset_r <= 1'b1;
            u_weight_r  <= {WEIGHT_W{1'b0}};
            v_weight_r  <= {WEIGHT_W{1'b0}};
            range_err_r <= 1'b0;
            u_lt_r      <= 1'b0;
          end
        end
        ST_LOAD_U: begin
          // The accumulator is registered, so u_weight trails it by one cycle.
          u_weight_r <= weight_s;
          if (accept_s) begin
            idx_r <= idx_r + 6'd1;
            if (idx_r == 6'd15) begin
              state_r <= ST_LOAD_V;
            end
          end
        end
        ST_LOAD_V: begin
          // Until the first v word lands the chain still holds the u result.
          if (idx_r == 6'd16) begin
            u_weight_r <= weight_s;
            u_lt_r     <= borrow_s;
          end else begin
            v_weight_r <= weight_s;
          end
          if (accept_s) begin
            idx_r <= idx_r + 6'd1;
            if (idx_r == 6'd31) begin
              state_r    <= ST_CHECK;
              in_ready_r <= 1'b0;
            end
          end
        end
        ST_CHECK: begin
          // The chain now holds the v result directly.
          v_weight_r <= weight_s;
          if (u_lt_r && borrow_s) begin
            mul_reset_r <= 1'b0;
            bus_r       <= buffer_r[0];
            idx_r       <= 6'd1;
            state_r     <= ST_STREAM;
          end else begin
            range_err_r <= 1'b1;
            state_r     <= ST_ERR;
          end
        end
        ST_STREAM: begin
          if (idx_r == 6'd32) begin
            bus_r         <= {WORD_SIZE{1'b0}};
            stream_done_r <= 1'b1;
            state_r       <= ST_DONE;
          end else begin
            bus_r <= buffer_r[idx_r[4:0]];
            idx_r <= idx_r + 6'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_mont_operand_loader
// Self-checking bench: words are pushed to a scoreboard as they are accepted
// and popped as the loader streams them to the multiplier bus.
// ---------------------------------------------------------------------------
module tb_mont_operand_loader;
  import mont_pkg::*;

  logic                clk;
  logic                reset_n;
  logic                start;
  logic [WEIGHT_W-1:0] u_weight;
  logic [WEIGHT_W-1:0] v_weight;
  logic                range_err;
  logic                stream_done;

  mont_operand_loader_if ifc ();

  mont_operand_loader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .io          (ifc.slave),
    .u_weight    (u_weight),
    .v_weight    (v_weight),
    .range_err   (range_err),
    .stream_done (stream_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = 0;
  logic [WORD_SIZE-1:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] wsum(input logic [1023:0] x);
    logic [79:0] s;
    s = 80'd0;
    for (int i = 0; i < 16; i++) s = s + {16'd0, x[i*64 +: 64]};
    return s;
  endfunction

  task automatic do_start(input bit junk_valid);
    start        = 1'b1;
    ifc.in_valid = junk_valid;
    ifc.in_word  = 64'hDEAD_BEEF_0BAD_F00D;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("start_in_ready", ifc.in_ready, 1);
    check_val("start_mul_reset", ifc.mul_reset, 1);
    check_val("start_range_err", range_err, 0);
    check_val("start_u_weight", u_weight, 0);
    check_val("start_v_weight", v_weight, 0);
  endtask

  task automatic load_ops(input logic [1023:0] u, input logic [1023:0] v, input bit gaps);
    int k;
    int guard;
    bit vld;
    logic rdy;
    logic [1023:0] sel;
    logic [63:0] w;
    k = 0; guard = 0; vld = 1'b1;
    while (k < 32 && guard < 200) begin
      sel = (k < 16) ? u : v;
      w = sel[(k & 15)*64 +: 64];
      ifc.in_word  = w;
      ifc.in_valid = vld;
      rdy = ifc.in_ready;
      @(posedge clk); #1;
      if (vld && rdy) begin
        exp_q.push_back(w);
        k++;
        last_acc = cyc;
      end
      if (gaps) vld = !vld;
      guard++;
    end
    ifc.in_valid = 1'b0;
    check_val("load_complete", k, 32);
    check_val("in_ready_drop", ifc.in_ready, 0);
  endtask

  task automatic check_stream(input int start_at, input int abort_at);
    logic [63:0] e;
    @(posedge clk); #1;
    check_val("mul_reset_release", ifc.mul_reset, 0);
    check_val("latency_word0", cyc - last_acc, 1);
    for (int i = 0; i < 32; i++) begin
      check_val("sb_empty", exp_q.size() == 0, 0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
      check_val("bus_word", ifc.bus, e);
      if (i == abort_at) begin
        reset_n = 1'b0;
        #1;
        check_val("rst_bus", ifc.bus, 0);
        check_val("rst_mul_reset", ifc.mul_reset, 1);
        check_val("rst_in_ready", ifc.in_ready, 0);
        check_val("rst_u_weight", u_weight, 0);
        check_val("rst_stream_done", stream_done, 0);
        return;
      end
      if (i == start_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (i < 31) check_val("stream_done_early", stream_done, 0);
    end
    check_val("stream_done", stream_done, 1);
    check_val("bus_idle", ifc.bus, 0);
    check_val("latency_done", cyc - last_acc, 33);
    @(posedge clk); #1;
    check_val("stream_done_pulse", stream_done, 0);
    check_val("done_mul_reset", ifc.mul_reset, 0);
  endtask

  task automatic check_error();
    int bad;
    bad = 0;
    @(posedge clk); #1;
    check_val("err_range_err", range_err, 1);
    check_val("err_mul_reset", ifc.mul_reset, 1);
    repeat (40) begin
      if (stream_done || !ifc.mul_reset || ifc.bus != 64'd0) bad++;
      @(posedge clk); #1;
    end
    check_val("err_quiet", bad, 0);
    check_val("err_held", range_err, 1);
    exp_q.delete();
  endtask

  task automatic run_case(input string name, input logic [1023:0] u, input logic [1023:0] v,
                          input bit gaps, input int start_at, input int abort_at);
    bit ok;
    do_start(1'b1);
    load_ops(u, v, gaps);
    ok = (u < N) && (v < N);
    if (ok) check_stream(start_at, abort_at);
    else    check_error();
    if (abort_at < 0) begin
      check_val({name, "_u_weight"}, u_weight, wsum(u));
      check_val({name, "_v_weight"}, v_weight, wsum(v));
    end
  endtask

  initial begin
    logic [1023:0] n_val;
    logic [1023:0] n_m1;
    logic [1023:0] ones;
    n_val = N;
    n_m1  = n_val - 1024'd1;
    ones  = ~(1024'd0);
    reset_n = 1'b0;
    start = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_word = 64'd0;
    #12;
    check_val("reset_in_ready", ifc.in_ready, 0);
    check_val("reset_bus", ifc.bus, 0);
    check_val("reset_mul_reset", ifc.mul_reset, 1);
    check_val("reset_u_weight", u_weight, 0);
    check_val("reset_v_weight", v_weight, 0);
    check_val("reset_range_err", range_err, 0);
    check_val("reset_stream_done", stream_done, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: small operands, junk word offered together with start
    run_case("t1", 1024'd1, 1024'd2, 1'b0, -1, -1);
    check_val("t1_u_weight_const", u_weight, 80'd1);
    check_val("t1_v_weight_const", v_weight, 80'd2);

    // 2: v equal to N is out of range
    run_case("t2", n_m1, n_val, 1'b0, -1, -1);

    // 3: gapped load must stream the same words
    run_case("t3", n_m1, 1024'd5, 1'b1, -1, -1);

    // 4: u all ones
    run_case("t4", ones, 1024'd3, 1'b0, -1, -1);
    check_val("t4_u_weight_const", u_weight, 80'hF_FFFF_FFFF_FFFF_FFF0);

    // 5: reset while word 10 is on the bus, then a full reload
    run_case("t5a", 1024'd0, n_m1, 1'b0, -1, 10);
    exp_q.delete();
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_case("t5b", 1024'd1, 1024'd2, 1'b0, -1, -1);

    // 6: start mid-stream is ignored; start in DONE restarts the load
    run_case("t6", 1024'd0, {n_m1[1023:64], 64'h1234_5678_9ABC_DEF0}, 1'b0, 5, -1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("t6_restart_mul_reset", ifc.mul_reset, 1);
    check_val("t6_restart_in_ready", ifc.in_ready, 1);
    check_val("t6_restart_u_weight", u_weight, 0);
    check_val("t6_restart_v_weight", v_weight, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
